// File: rtl/famiclone_detect.sv
// Power-on console-type detector: holds CIRAM /CE and /A13 low during INIT, then
// votes on synchronised PPU reads to tell a new-style famiclone from a classic console.
module famiclone_detect #(
    parameter int unsigned INIT_CYCLES        = 15,
    parameter int unsigned SAMPLES_LO         = 2,
    parameter int unsigned SAMPLES_HI         = 2,
    parameter int unsigned MISMATCH_THRESHOLD = 1,
    parameter int unsigned TIMEOUT_CYCLES     = 65535,
    parameter int unsigned ENABLE             = 1
) (
    input  logic m2,
    input  logic reset,
    input  logic ppu_rd_in,
    input  logic ppu_a13_in,
    input  logic ppu_not_a13_in,
    input  logic rearm,
    output logic hold_low,
    output logic detect_done,
    output logic new_dendy,
    output logic timed_out
);

    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned MM_W   = (MISMATCH_THRESHOLD == 0) ? 1 : $clog2(MISMATCH_THRESHOLD + 1);
    localparam int unsigned LO_W   = (SAMPLES_LO == 0) ? 1 : $clog2(SAMPLES_LO + 1);
    localparam int unsigned HI_W   = (SAMPLES_HI == 0) ? 1 : $clog2(SAMPLES_HI + 1);

    localparam logic [INIT_W-1:0] INIT_LOAD  = INIT_W'(INIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [MM_W-1:0]   MM_MAX     = MM_W'(MISMATCH_THRESHOLD);
    localparam logic [LO_W-1:0]   LO_MAX     = LO_W'(SAMPLES_LO);
    localparam logic [HI_W-1:0]   HI_MAX     = HI_W'(SAMPLES_HI);
    localparam logic              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic              ENABLED    = (ENABLE != 0);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_DETECT = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_RESET  = ENABLED ? ST_INIT : ST_DONE;

    logic [1:0]        state, state_n;
    logic [INIT_W-1:0] init_cnt, init_n;
    logic [TO_W-1:0]   to_cnt, to_n;
    logic [MM_W-1:0]   mm_cnt, mm_n;
    logic [LO_W-1:0]   lo_cnt, lo_n;
    logic [HI_W-1:0]   hi_cnt, hi_n;
    logic              nd_n, tmo_n;

    logic rd_s1, rd_s2, rd_prev;
    logic a13_s1, a13_s2;
    logic na13_s1, na13_s2;
    logic sample_valid, mismatch;

    // A read only counts once /RD has been seen low on two consecutive synced samples
    assign sample_valid = (state == ST_DETECT) && !rd_s2 && !rd_prev;
    assign mismatch     = (a13_s2 == na13_s2);

    // State, counters, synchronisers and registered outputs
    always_ff @(posedge m2) begin
        if (reset) begin
            state       <= ST_RESET;
            init_cnt    <= INIT_LOAD;
            to_cnt      <= '0;
            mm_cnt      <= '0;
            lo_cnt      <= '0;
            hi_cnt      <= '0;
            rd_s1       <= 1'b1;
            rd_s2       <= 1'b1;
            rd_prev     <= 1'b1;
            a13_s1      <= 1'b1;
            a13_s2      <= 1'b1;
            na13_s1     <= 1'b1;
            na13_s2     <= 1'b1;
            hold_low    <= ENABLED;
            detect_done <= !ENABLED;
            new_dendy   <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            state       <= state_n;
            init_cnt    <= init_n;
            to_cnt      <= to_n;
            mm_cnt      <= mm_n;
            lo_cnt      <= lo_n;
            hi_cnt      <= hi_n;
            rd_s1       <= ppu_rd_in;
            rd_s2       <= rd_s1;
            rd_prev     <= rd_s2;
            a13_s1      <= ppu_a13_in;
            a13_s2      <= a13_s1;
            na13_s1     <= ppu_not_a13_in;
            na13_s2     <= na13_s1;
            hold_low    <= (state_n == ST_INIT);
            detect_done <= (state_n == ST_DONE);
            new_dendy   <= nd_n;
            timed_out   <= tmo_n;
        end
    end

    // Next-state, vote counting and result decision
    always_comb begin
        state_n = state;
        init_n  = init_cnt;
        to_n    = to_cnt;
        mm_n    = mm_cnt;
        lo_n    = lo_cnt;
        hi_n    = hi_cnt;
        nd_n    = new_dendy;
        tmo_n   = timed_out;

        case (state)
            ST_INIT: begin
                if (init_cnt == '0) begin
                    state_n = ST_DETECT;
                    to_n    = '0;
                    mm_n    = '0;
                    lo_n    = '0;
                    hi_n    = '0;
                end else begin
                    init_n = init_cnt - INIT_W'(1);
                end
            end

            ST_DETECT: begin
                if (sample_valid) begin
                    if (mismatch && (mm_cnt != MM_MAX)) mm_n = mm_cnt + MM_W'(1);
                    if (!a13_s2 && (lo_cnt != LO_MAX)) lo_n = lo_cnt + LO_W'(1);
                    if (a13_s2 && (hi_cnt != HI_MAX)) hi_n = hi_cnt + HI_W'(1);
                end
                if (to_cnt != '1) to_n = to_cnt + TO_W'(1);

                // Decisions use counts that already include this cycle's sample
                if (mm_n == MM_MAX) begin
                    state_n = ST_DONE;
                    nd_n    = 1'b1;
                end else if ((lo_n == LO_MAX) && (hi_n == HI_MAX)) begin
                    state_n = ST_DONE;
                end else if (TIMEOUT_EN && (to_cnt == TO_LAST)) begin
                    state_n = ST_DONE;
                    tmo_n   = 1'b1;
                end
            end

            ST_DONE: begin
                if (ENABLED && rearm) begin
                    state_n = ST_INIT;
                    init_n  = INIT_LOAD;
                    nd_n    = 1'b0;
                    tmo_n   = 1'b0;
                end
            end

            default: begin
                state_n = ST_RESET;
                init_n  = INIT_LOAD;
                nd_n    = 1'b0;
                tmo_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_famiclone_detect.sv
// Bench for famiclone_detect: three configurations driven in parallel, checked every
// cycle against a pin-history reference model plus a table of hand-derived checkpoints.
module tb_famiclone_detect;

    logic m2 = 1'b0;
    logic reset, rearm, ppu_rd_in, ppu_a13_in, ppu_not_a13_in;
    logic [2:0] hold_v, done_v, nd_v, to_v;

    always #5 m2 = ~m2;

    // 0: defaults, 1: threshold 4 with 100-cycle timeout, 2: disabled
    famiclone_detect u_def (
        .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13_in(ppu_a13_in),
        .ppu_not_a13_in(ppu_not_a13_in), .rearm(rearm),
        .hold_low(hold_v[0]), .detect_done(done_v[0]), .new_dendy(nd_v[0]), .timed_out(to_v[0])
    );

    famiclone_detect #(.MISMATCH_THRESHOLD(4), .TIMEOUT_CYCLES(100)) u_th4 (
        .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13_in(ppu_a13_in),
        .ppu_not_a13_in(ppu_not_a13_in), .rearm(rearm),
        .hold_low(hold_v[1]), .detect_done(done_v[1]), .new_dendy(nd_v[1]), .timed_out(to_v[1])
    );

    famiclone_detect #(.ENABLE(0)) u_off (
        .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13_in(ppu_a13_in),
        .ppu_not_a13_in(ppu_not_a13_in), .rearm(rearm),
        .hold_low(hold_v[2]), .detect_done(done_v[2]), .new_dendy(nd_v[2]), .timed_out(to_v[2])
    );

    int init_c[3] = '{15, 15, 15};
    int lo_c[3]   = '{2, 2, 2};
    int hi_c[3]   = '{2, 2, 2};
    int th_c[3]   = '{1, 4, 1};
    int tmo_c[3]  = '{65535, 100, 65535};
    int en_c[3]   = '{1, 1, 0};

    // phase: 0 = INIT, 1 = DETECT, 2 = DONE
    typedef struct {
        int phase;
        int init_el;
        int det;
        int mm;
        int lo;
        int hi;
        bit nd;
        bit to;
    } mdl_t;
    mdl_t m[3];

    // Pins as seen at the last three edges; index 0 is the most recent
    bit rd_h[3];
    bit a_h[3];
    bit n_h[3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [3:0] got_of(input int i);
        return {hold_v[i], done_v[i], nd_v[i], to_v[i]};
    endfunction

    function automatic logic [3:0] exp_of(input int i);
        return {m[i].phase == 0, m[i].phase == 2, m[i].nd, m[i].to};
    endfunction

    task automatic model_step(input bit rst, input bit re, input bit rd, input bit a, input bit n);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m[i] = '{phase: (en_c[i] != 0) ? 0 : 2, init_el: 0, det: 0, mm: 0, lo: 0, hi: 0,
                         nd: 1'b0, to: 1'b0};
            end else if (m[i].phase == 0) begin
                m[i].init_el++;
                if (m[i].init_el == init_c[i]) begin
                    m[i].phase = 1;
                    m[i].det = 0;
                    m[i].mm = 0;
                    m[i].lo = 0;
                    m[i].hi = 0;
                end
            end else if (m[i].phase == 1) begin
                m[i].det++;
                if (!rd_h[1] && !rd_h[2]) begin
                    if (a_h[1] == n_h[1]) m[i].mm = min2(m[i].mm + 1, th_c[i]);
                    if (!a_h[1]) m[i].lo = min2(m[i].lo + 1, lo_c[i]);
                    else         m[i].hi = min2(m[i].hi + 1, hi_c[i]);
                end
                if (m[i].mm == th_c[i]) begin
                    m[i].phase = 2;
                    m[i].nd = 1'b1;
                end else if (m[i].lo == lo_c[i] && m[i].hi == hi_c[i]) begin
                    m[i].phase = 2;
                end else if (tmo_c[i] != 0 && m[i].det == tmo_c[i]) begin
                    m[i].phase = 2;
                    m[i].to = 1'b1;
                end
            end else begin
                if (en_c[i] != 0 && re) begin
                    m[i].phase = 0;
                    m[i].init_el = 0;
                    m[i].nd = 1'b0;
                    m[i].to = 1'b0;
                end
            end
        end
        if (rst) begin
            rd_h = '{1'b1, 1'b1, 1'b1};
            a_h  = '{1'b1, 1'b1, 1'b1};
            n_h  = '{1'b1, 1'b1, 1'b1};
        end else begin
            rd_h[2] = rd_h[1]; rd_h[1] = rd_h[0]; rd_h[0] = rd;
            a_h[2]  = a_h[1];  a_h[1]  = a_h[0];  a_h[0]  = a;
            n_h[2]  = n_h[1];  n_h[1]  = n_h[0];  n_h[0]  = n;
        end
    endtask

    // One m2 cycle: drive, clock, advance the model, compare all three instances
    task automatic apply(input bit rst, input bit re, input bit rd, input bit a, input bit n);
        reset = rst;
        rearm = re;
        ppu_rd_in = rd;
        ppu_a13_in = a;
        ppu_not_a13_in = n;
        @(posedge m2);
        model_step(rst, re, rd, a, n);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got_of(i) !== exp_of(i)) begin
                n_bad++;
                $display("FAIL model inst%0d cycle %0d: got {hold,done,nd,to}=%b expected %b",
                         i, cyc, got_of(i), exp_of(i));
            end
        end
    endtask

    typedef struct {
        int         cycles;
        bit         rst;
        bit         re;
        bit         rd;
        bit         a;
        bit         n;
        int         inst;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int c, input bit rst, input bit re, input bit rd, input bit a,
                       input bit n, input int inst, input logic [3:0] exp);
        tbl.push_back('{cycles: c, rst: rst, re: re, rd: rd, a: a, n: n, inst: inst, exp: exp});
    endtask

    initial begin
        bit rd_r;
        bit a_r;
        // cycles rst re rd a n inst {hold,done,nd,to}
        // Classic console on defaults, then rearm and a famiclone run
        add(1,  1, 0, 1, 0, 1, 0, 4'b1000);
        add(14, 0, 0, 1, 0, 1, 0, 4'b1000);
        add(1,  0, 0, 1, 0, 1, 0, 4'b0000);
        add(4,  0, 0, 0, 0, 1, 0, 4'b0000);
        add(1,  0, 0, 0, 0, 1, 0, 4'b0000);
        add(3,  0, 0, 0, 1, 0, 0, 4'b0000);
        add(1,  0, 0, 0, 1, 0, 0, 4'b0100);
        add(1,  0, 1, 1, 0, 1, 0, 4'b1000);
        add(14, 0, 0, 1, 0, 1, 0, 4'b1000);
        add(1,  0, 0, 1, 0, 1, 0, 4'b0000);
        add(3,  0, 0, 0, 1, 1, 0, 4'b0000);
        add(1,  0, 0, 0, 1, 1, 0, 4'b0110);
        add(1,  0, 1, 1, 0, 1, 2, 4'b0100);
        // Glitch rejection and 100-cycle timeout
        add(1,  1, 0, 1, 0, 1, 1, 4'b1000);
        add(15, 0, 0, 1, 0, 1, 1, 4'b0000);
        add(1,  0, 0, 0, 1, 1, 0, 4'b0000);
        add(1,  0, 0, 1, 1, 1, 0, 4'b0000);
        add(1,  0, 0, 0, 1, 1, 0, 4'b0000);
        add(1,  0, 0, 1, 1, 1, 0, 4'b0000);
        add(95, 0, 0, 1, 0, 1, 1, 4'b0000);
        add(1,  0, 0, 1, 0, 1, 1, 4'b0101);
        add(1,  0, 0, 1, 0, 1, 0, 4'b0000);
        // Threshold 4: fourth mismatching sample also completes 2 lo + 2 hi
        add(1,  1, 0, 1, 0, 1, 1, 4'b1000);
        add(15, 0, 0, 1, 0, 1, 1, 4'b0000);
        add(3,  0, 0, 0, 0, 0, 1, 4'b0000);
        add(3,  0, 0, 1, 0, 0, 1, 4'b0000);
        add(3,  0, 0, 0, 1, 1, 1, 4'b0000);
        add(1,  0, 0, 1, 1, 1, 1, 4'b0000);
        add(1,  0, 0, 1, 1, 1, 1, 4'b0110);
        // Rearm, then reset in the middle of DETECT
        add(1,  0, 1, 1, 0, 1, 1, 4'b1000);
        add(15, 0, 0, 1, 0, 1, 1, 4'b0000);
        add(2,  0, 0, 0, 0, 1, 1, 4'b0000);
        add(1,  1, 0, 0, 0, 1, 1, 4'b1000);
        add(14, 0, 0, 1, 0, 1, 1, 4'b1000);
        add(1,  0, 0, 1, 0, 1, 1, 4'b0000);

        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].cycles; k++)
                apply(tbl[r].rst, tbl[r].re, tbl[r].rd, tbl[r].a, tbl[r].n);
            n_cmp++;
            if (got_of(tbl[r].inst) !== tbl[r].exp) begin
                n_bad++;
                $display("FAIL table row %0d inst%0d: got {hold,done,nd,to}=%b expected %b",
                         r, tbl[r].inst, got_of(tbl[r].inst), tbl[r].exp);
            end
        end

        // Random bursts of reads, mostly classic levels, occasional rearm and reset
        rd_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0) rd_r = !rd_r;
            a_r = 1'($urandom_range(0, 1));
            apply($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, rd_r, a_r,
                  ($urandom_range(0, 7) == 0) ? a_r : !a_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
